dds_cmd_parser: RTL and testbench
=================================

Name: dds_cmd_parser

Overview:
- Control-side initiator for the DDS driver's configuration interface.
- Consumes a byte stream from the Ethernet/UDP receive path and decodes fixed 8-byte command frames.
- Drives the DDS value/strobe pairs: run, fword, pword, mode and duty.
- Flags each frame with a one-cycle ok or err pulse.

Parameters:
HDR0, 8'h55, first header byte
HDR1, 8'hAA, second header byte
DUTY_MAX, 1000, largest legal duty value (0.1 % units)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_data  in  8  stream byte
i_valid  in  1  byte qualifier; no backpressure, every valid byte is consumed
i_last  in  1  last byte of packet, qualified by i_valid
o_run  out  1  run enable
o_run_vld  out  1  run update strobe
o_fword  out  27  frequency word
o_fword_vld  out  1  fword update strobe
o_pword  out  8  phase word
o_pword_vld  out  1  pword update strobe
o_mode  out  3  waveform mode (0 sin, 1 squ, 2 tri, 3 saw, 4 lfsr, 5 pulse)
o_dds_duty  out  10  square duty
o_dds_duty_vld  out  1  duty update strobe
o_mode_vld  out  1  mode update strobe
o_frame_ok  out  1  one-cycle pulse, frame applied
o_frame_err  out  1  one-cycle pulse, frame rejected

Behaviour:
- Single clock domain. All registers use i_rst synchronously; i_rst has priority over every input.
- Reset values:
  - o_run=1, o_fword=320000, o_pword=0, o_mode=0, o_dds_duty=500.
  - All *_vld outputs, o_frame_ok and o_frame_err are 0.
  - FSM state is IDLE.
- Frame format, 8 bytes:
  - Byte 0: HDR0. Byte 1: HDR1. Byte 2: CMD.
  - Bytes 3..6: P3..P0, payload big-endian, 32 bits.
  - Byte 7: CHK = CMD ^ P3 ^ P2 ^ P1 ^ P0.
  - i_last is asserted only on CHK.
- FSM states: IDLE, H1, CMD, PAY, CHK, DISCARD. States change only on cycles where i_valid=1.
  - IDLE: byte==HDR0 and !i_last -> H1. Any other byte stays in IDLE, with no error.
  - H1:
    - byte==HDR1 -> CMD.
    - byte==HDR0 -> stay in H1 (resync).
    - Any other byte -> IDLE, no error.
  - CMD: latch CMD, start the XOR accumulator, -> PAY with a 2-bit byte counter cleared.
  - PAY: shift bytes into the 32-bit payload register and XOR-accumulate. The 4th byte -> CHK.
  - CHK: evaluate the frame (rules below), then -> IDLE on success or error.
  - DISCARD: drop bytes until a valid byte with i_last=1, then -> IDLE. No further pulses are issued.
- i_last in H1/CMD/PAY (short frame): pulse o_frame_err, -> IDLE.
- CHK byte without i_last (long frame): pulse o_frame_err, -> DISCARD. Nothing is applied.
- CHK byte with i_last is accepted only if all of these hold; otherwise pulse o_frame_err and apply nothing:
  - the checksum matches;
  - CMD is in 0x01..0x05;
  - for CMD 0x05, payload[9:0] <= DUTY_MAX and payload[31:10]==0.
- Command map:
  - 0x01: o_run = P0[0]
  - 0x02: o_fword = payload[26:0]; bits 31:27 are ignored
  - 0x03: o_pword = P0
  - 0x04: o_mode = payload[2:0]; values 6/7 are passed through
  - 0x05: o_dds_duty = payload[9:0]
- Latency: on the cycle after the accepted CHK byte, three things happen together:
  - the target value register updates;
  - its *_vld pulses high for exactly one cycle;
  - o_frame_ok pulses.
  - The value holds until the next accepted frame for the same field. Other fields are untouched.
- o_frame_err timing: pulses the cycle after the offending byte.
- Strobes: a field's *_vld is never high for two consecutive cycles from one frame. Back-to-back frames can produce a strobe at most once every 8 valid bytes.
- Gaps: i_valid gaps of any length inside a frame are legal and do not time out.
- Reset during a frame: the partial frame is dropped and no strobes are issued. The next HDR0 starts fresh.

Test Plan:
- Reset, no input -> outputs hold 1/320000/0/0/500, all strobes 0.
- Frame 55 AA 02 00 05 00 00 07 (last on 07) -> o_fword=0x050000 and o_fword_vld=1 for one cycle, 1 cycle after the 07 byte. o_frame_ok=1. All other fields unchanged.
- Frame 55 AA 05 00 00 01 F4 F0 (duty 500) -> duty_vld, o_dds_duty=500. Same frame with payload 0x3E9 (1001) and matching CHK -> o_frame_err, duty stays 500.
- Bad checksum 55 AA 03 00 00 00 10 00 -> o_frame_err, o_pword unchanged. Then a good pword frame with P0=0x10 -> o_pword=0x10, pword_vld.
- Resync/noise: bytes 00 55 55 AA 04 00 00 00 03 07 with i_valid gaps of 3 cycles -> o_mode=3 with mode_vld, and no error pulses from the leading noise.
- Framing errors:
  - i_last on P2 -> o_frame_err, back to IDLE.
  - 9-byte frame (last on the extra byte) -> a single o_frame_err on the CHK byte, no strobes, and the next frame decodes normally.
  - i_rst asserted mid-payload -> no strobes, and values return to reset defaults.

Source files
------------

// File: rtl/dds_cmd_parser.sv
// Decodes 8-byte command frames (55 AA CMD P3 P2 P1 P0 CHK) from a byte stream
// and drives the DDS value/strobe pairs plus frame ok/err pulses.
//
// state   | meaning
// IDLE    | hunting for HDR0
// H1      | HDR0 seen, expecting HDR1
// CMD     | expecting command byte
// PAY     | collecting the 4 payload bytes, big-endian
// CHK     | expecting checksum byte, which must carry i_last
// DISCARD | overlong frame, dropping bytes up to i_last
module dds_cmd_parser #(
  parameter logic [7:0] HDR0     = 8'h55,
  parameter logic [7:0] HDR1     = 8'hAA,
  parameter int         DUTY_MAX = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  input  logic        i_last,
  output logic        o_run,
  output logic        o_run_vld,
  output logic [26:0] o_fword,
  output logic        o_fword_vld,
  output logic [7:0]  o_pword,
  output logic        o_pword_vld,
  output logic [2:0]  o_mode,
  output logic [9:0]  o_dds_duty,
  output logic        o_dds_duty_vld,
  output logic        o_mode_vld,
  output logic        o_frame_ok,
  output logic        o_frame_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_H1, S_CMD, S_PAY, S_CHK, S_DISCARD
  } state_t;

  state_t      state;
  logic [7:0]  cmd_q;
  logic [31:0] payload_q;
  logic [7:0]  xor_q;
  logic [1:0]  cnt_q;

  logic chk_ok, cmd_ok, duty_ok, frame_good;

  assign chk_ok     = (xor_q == i_data);
  assign cmd_ok     = (cmd_q >= 8'h01) && (cmd_q <= 8'h05);
  assign duty_ok    = (payload_q <= 32'(DUTY_MAX));
  assign frame_good = chk_ok && cmd_ok && ((cmd_q != 8'h05) || duty_ok);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= S_IDLE;
      cmd_q          <= '0;
      payload_q      <= '0;
      xor_q          <= '0;
      cnt_q          <= '0;
      o_run          <= 1'b1;
      o_fword        <= 27'd320000;
      o_pword        <= '0;
      o_mode         <= '0;
      o_dds_duty     <= 10'd500;
      o_run_vld      <= 1'b0;
      o_fword_vld    <= 1'b0;
      o_pword_vld    <= 1'b0;
      o_mode_vld     <= 1'b0;
      o_dds_duty_vld <= 1'b0;
      o_frame_ok     <= 1'b0;
      o_frame_err    <= 1'b0;
    end else begin
      o_run_vld      <= 1'b0;
      o_fword_vld    <= 1'b0;
      o_pword_vld    <= 1'b0;
      o_mode_vld     <= 1'b0;
      o_dds_duty_vld <= 1'b0;
      o_frame_ok     <= 1'b0;
      o_frame_err    <= 1'b0;
      if (i_valid) begin
        case (state)
          S_IDLE: if (i_data == HDR0 && !i_last) state <= S_H1;
          S_H1: begin
            if (i_last) begin
              o_frame_err <= 1'b1;
              state       <= S_IDLE;
            end else if (i_data == HDR1) begin
              state <= S_CMD;
            end else if (i_data != HDR0) begin
              state <= S_IDLE;
            end
          end
          S_CMD: begin
            if (i_last) begin
              o_frame_err <= 1'b1;
              state       <= S_IDLE;
            end else begin
              cmd_q <= i_data;
              xor_q <= i_data;
              cnt_q <= '0;
              state <= S_PAY;
            end
          end
          S_PAY: begin
            if (i_last) begin
              o_frame_err <= 1'b1;
              state       <= S_IDLE;
            end else begin
              payload_q <= {payload_q[23:0], i_data};
              xor_q     <= xor_q ^ i_data;
              cnt_q     <= cnt_q + 2'd1;
              if (cnt_q == 2'd3) state <= S_CHK;
            end
          end
          S_CHK: begin
            if (!i_last) begin
              o_frame_err <= 1'b1;
              state       <= S_DISCARD;
            end else begin
              state <= S_IDLE;
              if (frame_good) begin
                o_frame_ok <= 1'b1;
                case (cmd_q[2:0])
                  3'd1: begin o_run      <= payload_q[0];    o_run_vld      <= 1'b1; end
                  3'd2: begin o_fword    <= payload_q[26:0]; o_fword_vld    <= 1'b1; end
                  3'd3: begin o_pword    <= payload_q[7:0];  o_pword_vld    <= 1'b1; end
                  3'd4: begin o_mode     <= payload_q[2:0];  o_mode_vld     <= 1'b1; end
                  3'd5: begin o_dds_duty <= payload_q[9:0];  o_dds_duty_vld <= 1'b1; end
                  default: ;
                endcase
              end else begin
                o_frame_err <= 1'b1;
              end
            end
          end
          S_DISCARD: if (i_last) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_cmd_parser.sv
// Bench for dds_cmd_parser: directed byte table plus randomized frames,
// every cycle compared against a frame-level reference model.
module tb_dds_cmd_parser;

  logic        i_clk, i_rst, i_valid, i_last;
  logic [7:0]  i_data;
  logic        o_run, o_run_vld, o_fword_vld, o_pword_vld, o_dds_duty_vld, o_mode_vld;
  logic        o_frame_ok, o_frame_err;
  logic [26:0] o_fword;
  logic [7:0]  o_pword;
  logic [2:0]  o_mode;
  logic [9:0]  o_dds_duty;

  dds_cmd_parser dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
    .o_run(o_run), .o_run_vld(o_run_vld), .o_fword(o_fword), .o_fword_vld(o_fword_vld),
    .o_pword(o_pword), .o_pword_vld(o_pword_vld), .o_mode(o_mode),
    .o_dds_duty(o_dds_duty), .o_dds_duty_vld(o_dds_duty_vld), .o_mode_vld(o_mode_vld),
    .o_frame_ok(o_frame_ok), .o_frame_err(o_frame_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // pulse vector: {ok, err, run_vld, fword_vld, pword_vld, mode_vld, duty_vld}
  localparam logic [6:0] P_NONE = 7'b0000000;
  localparam logic [6:0] P_ERR  = 7'b0100000;
  localparam logic [6:0] P_RUN  = 7'b1010000;
  localparam logic [6:0] P_FW   = 7'b1001000;
  localparam logic [6:0] P_PW   = 7'b1000100;
  localparam logic [6:0] P_MODE = 7'b1000010;
  localparam logic [6:0] P_DUTY = 7'b1000001;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic [6:0] e;
  } vec_t;

  vec_t tab[$];
  int   tests = 0;
  int   fails = 0;

  // reference model state
  logic        m_run;
  logic [26:0] m_fword;
  logic [7:0]  m_pword;
  logic [2:0]  m_mode;
  logic [9:0]  m_duty;
  logic [6:0]  m_pulse;
  logic [7:0]  frm[$];
  bit          m_disc;

  function automatic logic [6:0] act_pulse();
    return {o_frame_ok, o_frame_err, o_run_vld, o_fword_vld, o_pword_vld, o_mode_vld, o_dds_duty_vld};
  endfunction

  task automatic model_defaults();
    m_run = 1'b1; m_fword = 27'd320000; m_pword = 8'd0; m_mode = 3'd0; m_duty = 10'd500;
    m_pulse = P_NONE; frm.delete(); m_disc = 1'b0;
  endtask

  task automatic model(input logic v, input logic [7:0] d, input logic l, input logic r);
    logic [7:0]  x;
    logic [31:0] pl;
    m_pulse = P_NONE;
    if (r) begin model_defaults(); return; end
    if (!v) return;
    if (m_disc) begin
      if (l) m_disc = 1'b0;
      return;
    end
    case (frm.size())
      0: if (d == 8'h55 && !l) frm.push_back(d);
      1: begin
        if (l) begin m_pulse = P_ERR; frm.delete(); end
        else if (d == 8'hAA) frm.push_back(d);
        else if (d != 8'h55) frm.delete();
      end
      7: begin
        if (!l) begin
          m_pulse = P_ERR; m_disc = 1'b1;
        end else begin
          x  = frm[2] ^ frm[3] ^ frm[4] ^ frm[5] ^ frm[6];
          pl = {frm[3], frm[4], frm[5], frm[6]};
          if (x == d && frm[2] >= 8'd1 && frm[2] <= 8'd5 && (frm[2] != 8'd5 || pl <= 32'd1000)) begin
            case (frm[2])
              8'd1: begin m_run   = pl[0];     m_pulse = P_RUN;  end
              8'd2: begin m_fword = pl[26:0];  m_pulse = P_FW;   end
              8'd3: begin m_pword = pl[7:0];   m_pulse = P_PW;   end
              8'd4: begin m_mode  = pl[2:0];   m_pulse = P_MODE; end
              default: begin m_duty = pl[9:0]; m_pulse = P_DUTY; end
            endcase
          end else begin
            m_pulse = P_ERR;
          end
        end
        frm.delete();
      end
      default: begin
        if (l) begin m_pulse = P_ERR; frm.delete(); end
        else frm.push_back(d);
      end
    endcase
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic r);
    logic [55:0] act, exp;
    i_valid = v; i_data = d; i_last = l; i_rst = r;
    @(posedge i_clk); #1;
    model(v, d, l, r);
    act = {act_pulse(), o_run, o_fword, o_pword, o_mode, o_dds_duty};
    exp = {m_pulse, m_run, m_fword, m_pword, m_mode, m_duty};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL model t=%0t byte=%h v=%b l=%b: pulses/run/fword/pword/mode/duty got %b %b %h %h %0d %0d want %b %b %h %h %0d %0d",
               $time, d, v, l, act_pulse(), o_run, o_fword, o_pword, o_mode, o_dds_duty,
               m_pulse, m_run, m_fword, m_pword, m_mode, m_duty);
    end
  endtask

  task automatic chk_val(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic l, input logic [6:0] e);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.e = e;
    tab.push_back(t);
  endtask

  task automatic addg(input logic [7:0] d, input logic l, input logic [6:0] e);
    add(1'b1, d, l, e);
    for (int g = 0; g < 3; g++) add(1'b0, 8'h55, 1'b1, P_NONE);
  endtask

  task automatic add7(input logic [7:0] c, input logic [7:0] p3, input logic [7:0] p2,
                      input logic [7:0] p1, input logic [7:0] p0);
    add(1, 8'h55, 0, P_NONE); add(1, 8'hAA, 0, P_NONE); add(1, c, 0, P_NONE);
    add(1, p3, 0, P_NONE); add(1, p2, 0, P_NONE); add(1, p1, 0, P_NONE); add(1, p0, 0, P_NONE);
  endtask

  initial begin
    logic [7:0]  fb[$];
    logic [7:0]  c;
    logic [31:0] pl;
    int          kind, n, rst_at;

    model_defaults();
    i_valid = 0; i_data = 0; i_last = 0; i_rst = 1;
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    chk_val("rst_run", 32'(o_run), 32'd1);
    chk_val("rst_fword", 32'(o_fword), 32'd320000);
    chk_val("rst_pword", 32'(o_pword), 32'd0);
    chk_val("rst_mode", 32'(o_mode), 32'd0);
    chk_val("rst_duty", 32'(o_dds_duty), 32'd500);
    chk_val("rst_pulses", 32'(act_pulse()), 32'd0);

    // directed byte table
    add7(8'h02, 8'h00, 8'h05, 8'h00, 8'h00); add(1, 8'h07, 1, P_FW);
    add(0, 8'h00, 0, P_NONE);
    add7(8'h05, 8'h00, 8'h00, 8'h01, 8'hF4); add(1, 8'hF0, 1, P_DUTY);
    add7(8'h05, 8'h00, 8'h00, 8'h03, 8'hE9); add(1, 8'hEF, 1, P_ERR);
    add7(8'h03, 8'h00, 8'h00, 8'h00, 8'h10); add(1, 8'h00, 1, P_ERR);
    add7(8'h03, 8'h00, 8'h00, 8'h00, 8'h10); add(1, 8'h13, 1, P_PW);
    addg(8'h00, 0, P_NONE); addg(8'h55, 0, P_NONE); addg(8'h55, 0, P_NONE);
    addg(8'hAA, 0, P_NONE); addg(8'h04, 0, P_NONE); addg(8'h00, 0, P_NONE);
    addg(8'h00, 0, P_NONE); addg(8'h00, 0, P_NONE); addg(8'h03, 0, P_NONE);
    addg(8'h07, 1, P_MODE);
    add(1, 8'h55, 0, P_NONE); add(1, 8'hAA, 0, P_NONE); add(1, 8'h01, 0, P_NONE);
    add(1, 8'h00, 0, P_NONE); add(1, 8'h00, 1, P_ERR);
    add7(8'h01, 8'h00, 8'h00, 8'h00, 8'h01); add(1, 8'h00, 0, P_ERR); add(1, 8'h33, 1, P_NONE);
    add7(8'h01, 8'h00, 8'h00, 8'h00, 8'h00); add(1, 8'h01, 1, P_RUN);
    add7(8'h06, 8'h00, 8'h00, 8'h00, 8'h00); add(1, 8'h06, 1, P_ERR);
    add(1, 8'h55, 1, P_NONE); add(1, 8'hAA, 0, P_NONE); add(1, 8'h01, 0, P_NONE);
    add(1, 8'h55, 0, P_NONE); add(1, 8'h12, 0, P_NONE);

    for (int i = 0; i < tab.size(); i++) begin
      step(tab[i].v, tab[i].d, tab[i].l, 0);
      tests++;
      if (act_pulse() !== tab[i].e) begin
        fails++;
        $display("FAIL table[%0d] pulses got %b want %b", i, act_pulse(), tab[i].e);
      end
    end
    chk_val("tab_run", 32'(o_run), 32'd0);
    chk_val("tab_fword", 32'(o_fword), 32'h050000);
    chk_val("tab_pword", 32'(o_pword), 32'h10);
    chk_val("tab_mode", 32'(o_mode), 32'd3);
    chk_val("tab_duty", 32'(o_dds_duty), 32'd500);

    // reset in the middle of a payload
    step(1, 8'h55, 0, 0); step(1, 8'hAA, 0, 0); step(1, 8'h02, 0, 0);
    step(1, 8'h12, 0, 0); step(1, 8'h34, 0, 0);
    step(1, 8'h56, 0, 1);
    chk_val("midrst_fword", 32'(o_fword), 32'd320000);
    chk_val("midrst_run", 32'(o_run), 32'd1);
    step(1, 8'h78, 0, 0); step(1, 8'h02, 0, 0); step(1, 8'h58, 1, 0);
    chk_val("midrst_pulses", 32'(act_pulse()), 32'd0);
    chk_val("midrst_duty", 32'(o_dds_duty), 32'd500);

    // randomized frames against the model
    for (int f = 0; f < 400; f++) begin
      kind = $urandom_range(0, 19);
      c    = (kind < 2) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(1, 5));
      pl   = $urandom;
      if (c == 8'd5 && $urandom_range(0, 3) != 0) pl = 32'($urandom_range(0, 1100));
      fb.delete();
      if (kind == 5) begin
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) fb.push_back(($urandom_range(0, 1) == 1) ? 8'h55 : 8'($urandom));
      end
      fb.push_back(8'h55); fb.push_back(8'hAA); fb.push_back(c);
      fb.push_back(pl[31:24]); fb.push_back(pl[23:16]); fb.push_back(pl[15:8]); fb.push_back(pl[7:0]);
      fb.push_back(c ^ pl[31:24] ^ pl[23:16] ^ pl[15:8] ^ pl[7:0] ^ ((kind == 2) ? 8'h01 : 8'h00));
      if (kind == 3) begin
        n = $urandom_range(2, 6);
        while (fb.size() > n + 1) void'(fb.pop_back());
      end
      if (kind == 4) begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) fb.push_back(8'($urandom));
      end
      rst_at = (kind == 6) ? $urandom_range(0, fb.size() - 1) : -1;
      for (int k = 0; k < fb.size(); k++) begin
        n = $urandom_range(0, 2);
        for (int g = 0; g < n; g++) step(0, 8'($urandom), 1'($urandom), 0);
        step(1, fb[k], (k == fb.size() - 1), (k == rst_at));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
